// File: rtl/lock_arbiter.sv
// rtl/lock_arbiter.sv - N-client accelerator lock with sticky round-robin requests, owner handoff and status register
//
// Optional inactivity watchdog: define LOCK_TIMEOUT_EN to force-release an owner
// that has not selected the bus for TIMEOUT_CYCLES cycles.
module lock_arbiter #(
    parameter int unsigned N_CLIENTS      = 2,
    parameter logic [31:0] LOCK_ADDR      = 32'd84,
    parameter logic [31:0] STATUS_ADDR    = 32'd88,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr_in         [0:N_CLIENTS-1],
    input  logic        wr_en_in        [0:N_CLIENTS-1],
    input  logic        select_in       [0:N_CLIENTS-1],
    input  logic [31:0] data_in         [0:N_CLIENTS-1],
    input  logic [31:0] data_from_accel,
    output logic [31:0] data_to_accel,
    output logic [31:0] addr_o,
    output logic        wr_en_o,
    output logic        accel_select_o,
    output logic [31:0] data_out        [0:N_CLIENTS-1]
);

    // Owner value N_CLIENTS encodes "nobody holds the lock".
    localparam logic [31:0] FREE_ID  = 32'(N_CLIENTS);
    localparam logic [0:0]  ST_FREE  = 1'b0;
    localparam logic [0:0]  ST_OWNED = 1'b1;

    // Elaboration-time guard on the legal parameter space.
    if (N_CLIENTS < 1 || N_CLIENTS > 31 || TIMEOUT_CYCLES < 2) begin : g_bad_params
        $error("lock_arbiter: N_CLIENTS must be 1..31 and TIMEOUT_CYCLES >= 2");
    end

    logic [31:0]          r_owner;
    logic [31:0]          r_rr_ptr;
    logic [N_CLIENTS-1:0] r_pending;

    logic [0:0]           w_state;
    logic [N_CLIENTS-1:0] w_owner_oh;
    logic [N_CLIENTS-1:0] w_req;
    logic [N_CLIENTS-1:0] w_cancel;
    logic [N_CLIENTS-1:0] w_cand;
    logic [N_CLIENTS-1:0] w_winner_oh;
    logic [N_CLIENTS-1:0] w_pending_next;
    logic                 w_owner_sel;
    logic                 w_owner_wr;
    logic [31:0]          w_owner_addr;
    logic [31:0]          w_owner_data;
    logic                 w_owner_cancel;
    logic                 w_force;
    logic                 w_release;
    logic                 w_have_winner;
    logic                 w_grant;
    logic [31:0]          w_winner;
    logic                 w_to_flag;

    assign w_state = (r_owner == FREE_ID) ? ST_FREE : ST_OWNED;

    // Decode lock-register writes per client and build the owner one-hot
    always_comb begin
        w_req      = '0;
        w_cancel   = '0;
        w_owner_oh = '0;
        for (int i = 0; i < N_CLIENTS; i++) begin
            if (select_in[i] && wr_en_in[i] && (addr_in[i] == LOCK_ADDR)) begin
                w_req[i]    = (data_in[i] == 32'd1);
                w_cancel[i] = (data_in[i] == 32'd0);
            end
            w_owner_oh[i] = (r_owner == 32'(i));
        end
    end

    // Pick out the owner's bus signals; everything reads zero while FREE
    always_comb begin
        w_owner_sel  = 1'b0;
        w_owner_wr   = 1'b0;
        w_owner_addr = '0;
        w_owner_data = '0;
        for (int i = 0; i < N_CLIENTS; i++) begin
            if (w_owner_oh[i]) begin
                w_owner_sel  = select_in[i];
                w_owner_wr   = wr_en_in[i];
                w_owner_addr = addr_in[i];
                w_owner_data = data_in[i];
            end
        end
    end

    // A request from the owner is meaningless; a cancel removes the client this very cycle.
    assign w_owner_cancel = |(w_owner_oh & w_cancel);
    assign w_cand         = (r_pending | w_req) & ~w_cancel & ~w_owner_oh;
    assign w_release      = (w_state == ST_OWNED) && (w_owner_cancel || w_force);

    // Round-robin search: lowest candidate above rr_ptr, else lowest at or below it
    always_comb begin
        logic        found_hi;
        logic        found_lo;
        logic [31:0] win_hi;
        logic [31:0] win_lo;
        found_hi    = 1'b0;
        found_lo    = 1'b0;
        win_hi      = '0;
        win_lo      = '0;
        w_winner_oh = '0;
        for (int j = 0; j < N_CLIENTS; j++) begin
            if (w_cand[j]) begin
                if (32'(j) > r_rr_ptr) begin
                    if (!found_hi) begin
                        found_hi = 1'b1;
                        win_hi   = 32'(j);
                    end
                end else if (!found_lo) begin
                    found_lo = 1'b1;
                    win_lo   = 32'(j);
                end
            end
        end
        w_have_winner = found_hi | found_lo;
        w_winner      = found_hi ? win_hi : win_lo;
        for (int j = 0; j < N_CLIENTS; j++) begin
            w_winner_oh[j] = w_have_winner && (w_winner == 32'(j));
        end
    end

    // Grant decision: FREE grants any candidate, OWNED only hands off on release
    always_comb begin
        w_grant = 1'b0;
        case (w_state)
            ST_FREE:  w_grant = w_have_winner;
            ST_OWNED: w_grant = w_have_winner && w_release;
            default:  w_grant = 1'b0;
        endcase
    end

    assign w_pending_next = w_cand & ~(w_grant ? w_winner_oh : '0);

    // Ownership, round-robin pointer and sticky request state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_owner   <= FREE_ID;
            r_rr_ptr  <= FREE_ID - 32'd1;
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_next;
            if (w_grant) begin
                r_owner  <= w_winner;
                r_rr_ptr <= w_winner;
            end else if (w_release) begin
                r_owner  <= FREE_ID;
            end
        end
    end

`ifdef LOCK_TIMEOUT_EN
    localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_count;
    logic             r_to_flag;
    logic             w_status_rd;

    // Any client doing a plain read of the status register clears the timeout flag
    always_comb begin
        w_status_rd = 1'b0;
        for (int i = 0; i < N_CLIENTS; i++) begin
            if (select_in[i] && !wr_en_in[i] && (addr_in[i] == STATUS_ADDR)) begin
                w_status_rd = 1'b1;
            end
        end
    end

    assign w_force   = (w_state == ST_OWNED) && !w_owner_sel && (r_count == CNT_LAST);
    assign w_to_flag = r_to_flag;

    // Owner inactivity counter (saturating) and sticky timeout flag; a new timeout beats a read-clear
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count   <= '0;
            r_to_flag <= 1'b0;
        end else begin
            if (w_grant || w_release || w_owner_sel || (w_state == ST_FREE)) begin
                r_count <= '0;
            end else if (r_count != CNT_LAST) begin
                r_count <= r_count + 1'b1;
            end
            if (w_force) begin
                r_to_flag <= 1'b1;
            end else if (w_status_rd) begin
                r_to_flag <= 1'b0;
            end
        end
    end
`else
    assign w_force   = 1'b0;
    assign w_to_flag = 1'b0;
`endif

    // Accelerator-side mux follows the owner with no added latency
    assign addr_o         = w_owner_addr;
    assign wr_en_o        = w_owner_wr;
    assign accel_select_o = w_owner_sel;
    assign data_to_accel  = w_owner_wr ? w_owner_data : 32'd0;

    // Per-client read data: lock register, status register, or the accelerator for the owner
    always_comb begin
        for (int i = 0; i < N_CLIENTS; i++) begin
            data_out[i] = '0;
            if (addr_in[i] == LOCK_ADDR) begin
                data_out[i] = r_owner;
            end else if (addr_in[i] == STATUS_ADDR) begin
                data_out[i] = {w_to_flag, 31'(r_pending)};
            end else if (w_owner_oh[i]) begin
                data_out[i] = data_from_accel;
            end
        end
    end

endmodule

// File: tb/tb_lock_arbiter.sv
// tb/tb_lock_arbiter.sv - directed and randomized self-checking bench for lock_arbiter
`timescale 1ns/1ps
module tb_lock_arbiter;

    localparam int          N   = 4;
    localparam int          TMO = 8;
    localparam logic [31:0] LA  = 32'd84;
    localparam logic [31:0] SA  = 32'd88;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] addr_in   [0:N-1];
    logic        wr_en_in  [0:N-1];
    logic        select_in [0:N-1];
    logic [31:0] data_in   [0:N-1];
    logic [31:0] data_from_accel;
    logic [31:0] data_to_accel;
    logic [31:0] addr_o;
    logic        wr_en_o;
    logic        accel_select_o;
    logic [31:0] data_out  [0:N-1];

    lock_arbiter #(
        .N_CLIENTS      (N),
        .LOCK_ADDR      (LA),
        .STATUS_ADDR    (SA),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .addr_in         (addr_in),
        .wr_en_in        (wr_en_in),
        .select_in       (select_in),
        .data_in         (data_in),
        .data_from_accel (data_from_accel),
        .data_to_accel   (data_to_accel),
        .addr_o          (addr_o),
        .wr_en_o         (wr_en_o),
        .accel_select_o  (accel_select_o),
        .data_out        (data_out)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Behavioural model: owner index (N = free), last granted index, pending set, idle count, timeout flag
    int       m_owner = N, m_last = N - 1, m_idle = 0;
    bit [N-1:0] m_pend = '0;
    bit       m_flag = 1'b0;
    int       n_owner = N, n_last = N - 1, n_idle = 0;
    bit [N-1:0] n_pend = '0;
    bit       n_flag = 1'b0;
    bit       armed = 1'b0;

    // Compare DUT outputs against the model, then work out the model's next state from this cycle's inputs
    always @(negedge clk) begin : model
        bit          owned, rel, frc, any_rd, lw;
        bit          req [N];
        bit          can [N];
        int          win, c;
        logic [31:0] e;
        owned = (m_owner != N);
        if (armed) begin
            if (owned) begin
                chk("addr_o", addr_o, addr_in[m_owner]);
                chk("wr_en_o", 32'(wr_en_o), 32'(wr_en_in[m_owner]));
                chk("accel_select_o", 32'(accel_select_o), 32'(select_in[m_owner]));
                chk("data_to_accel", data_to_accel, wr_en_in[m_owner] ? data_in[m_owner] : 32'd0);
            end else begin
                chk("addr_o free", addr_o, 32'd0);
                chk("wr_en_o free", 32'(wr_en_o), 32'd0);
                chk("accel_select_o free", 32'(accel_select_o), 32'd0);
                chk("data_to_accel free", data_to_accel, 32'd0);
            end
            for (int i = 0; i < N; i++) begin
                if (addr_in[i] == LA) e = 32'(m_owner);
                else if (addr_in[i] == SA) begin
                    e = 32'(m_pend);
                    if (m_flag) e[31] = 1'b1;
                end
                else if (i == m_owner) e = data_from_accel;
                else e = 32'd0;
                chk($sformatf("data_out[%0d]", i), data_out[i], e);
            end
        end
        if (!rst_n) begin
            n_owner = N; n_last = N - 1; n_pend = '0; n_idle = 0; n_flag = 1'b0;
        end else begin
            rel = 1'b0; frc = 1'b0; any_rd = 1'b0; win = -1;
            for (int i = 0; i < N; i++) begin
                lw     = select_in[i] && wr_en_in[i] && (addr_in[i] == LA);
                req[i] = lw && (data_in[i] == 32'd1);
                can[i] = lw && (data_in[i] == 32'd0);
                if (select_in[i] && !wr_en_in[i] && (addr_in[i] == SA)) any_rd = 1'b1;
            end
            if (owned && can[m_owner]) rel = 1'b1;
`ifdef LOCK_TIMEOUT_EN
            if (owned && !select_in[m_owner] && (m_idle >= TMO - 1)) begin
                frc = 1'b1;
                rel = 1'b1;
            end
`endif
            n_pend = m_pend;
            for (int i = 0; i < N; i++) begin
                if (req[i] && (i != m_owner)) n_pend[i] = 1'b1;
                if (can[i]) n_pend[i] = 1'b0;
            end
            n_owner = m_owner;
            n_last  = m_last;
            if (!owned || rel) begin
                for (int k = 1; k <= N; k++) begin
                    c = (m_last + k) % N;
                    if (win < 0 && n_pend[c]) win = c;
                end
                if (win >= 0) begin
                    n_owner = win;
                    n_last  = win;
                    n_pend[win] = 1'b0;
                end else begin
                    n_owner = N;
                end
            end
            if (win >= 0 || n_owner == N) n_idle = 0;
            else if (select_in[m_owner]) n_idle = 0;
            else n_idle = m_idle + 1;
            n_flag = frc ? 1'b1 : (any_rd ? 1'b0 : m_flag);
        end
    end

    always @(posedge clk) begin
        if (!rst_n) armed <= 1'b1;
        m_owner <= n_owner;
        m_last  <= n_last;
        m_pend  <= n_pend;
        m_idle  <= n_idle;
        m_flag  <= n_flag;
    end

    task automatic idle_all();
        for (int i = 0; i < N; i++) begin
            select_in[i] = 1'b0;
            wr_en_in[i]  = 1'b0;
            addr_in[i]   = 32'h1000;
            data_in[i]   = 32'd0;
        end
    endtask

    task automatic lock_wr(input int i, input logic [31:0] v);
        select_in[i] = 1'b1; wr_en_in[i] = 1'b1; addr_in[i] = LA; data_in[i] = v;
    endtask

    task automatic rd(input int i, input logic [31:0] a);
        select_in[i] = 1'b1; wr_en_in[i] = 1'b0; addr_in[i] = a; data_in[i] = 32'd0;
    endtask

    task automatic peek(input int i, input logic [31:0] a);
        select_in[i] = 1'b0; wr_en_in[i] = 1'b0; addr_in[i] = a; data_in[i] = 32'd0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        data_from_accel = $urandom;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1);
    end

    initial begin
        logic [31:0] st_exp [1:3];
        logic [31:0] v;
        int          r;
        st_exp[1] = 32'hC; st_exp[2] = 32'h8; st_exp[3] = 32'h0;
        idle_all();
        data_from_accel = 32'hA5A5_0000;
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;

        // Reset state
        for (int i = 0; i < N; i++) peek(i, LA);
        #1;
        for (int i = 0; i < N; i++) chk($sformatf("reset lock read %0d", i), data_out[i], 32'd4);
        chk("reset addr_o", addr_o, 32'd0);

        // First grant goes to client 0 one cycle after its request
        lock_wr(0, 32'd1);
        tick();
        idle_all();
        for (int i = 0; i < N; i++) peek(i, LA);
        #1;
        for (int i = 0; i < N; i++) chk($sformatf("grant lock read %0d", i), data_out[i], 32'd0);
        rd(0, 32'h40); rd(1, 32'h40);
        #1;
        chk("owner addr_o", addr_o, 32'h40);
        chk("owner select", 32'(accel_select_o), 32'd1);
        chk("owner read data", data_out[0], data_from_accel);
        chk("non-owner read data", data_out[1], 32'd0);

        // Three queued requests, then back-to-back handoffs
        tick();
        idle_all();
        lock_wr(1, 32'd1); lock_wr(2, 32'd1); lock_wr(3, 32'd1);
        tick();
        idle_all(); peek(1, SA);
        #1;
        chk("status three pending", data_out[1], 32'hE);
        for (int h = 1; h <= 3; h++) begin
            lock_wr(h - 1, 32'd0);
            tick();
            idle_all(); peek(0, LA); peek(1, SA);
            #1;
            chk($sformatf("handoff owner %0d", h), data_out[0], 32'(h));
            chk($sformatf("handoff status %0d", h), data_out[1], st_exp[h]);
        end
        lock_wr(3, 32'd0);
        tick();

        // rr_ptr = 0, then clients 0 and 1 request together: client 1 wins
        idle_all(); lock_wr(0, 32'd1); tick();
        idle_all(); lock_wr(0, 32'd0); tick();
        idle_all(); lock_wr(0, 32'd1); lock_wr(1, 32'd1); tick();
        idle_all(); peek(2, LA); peek(3, SA);
        #1;
        chk("rr winner", data_out[2], 32'd1);
        chk("rr loser pending", data_out[3], 32'h1);

        // Release and cancel in the same cycle leave the lock free
        lock_wr(1, 32'd0); lock_wr(0, 32'd0);
        tick();
        idle_all(); peek(2, LA); peek(3, SA);
        #1;
        chk("release+cancel owner", data_out[2], 32'd4);
        chk("release+cancel status", data_out[3], 32'd0);

`ifdef LOCK_TIMEOUT_EN
        lock_wr(0, 32'd1); tick();
        idle_all(); rd(0, 32'h10); lock_wr(1, 32'd1); tick();
        idle_all(); peek(2, LA);
        #1;
        chk("watchdog hold 1", data_out[2], 32'd0);
        for (int k = 2; k <= 8; k++) begin
            tick();
            #1;
            chk($sformatf("watchdog hold %0d", k), data_out[2], 32'd0);
        end
        tick();
        #1;
        chk("watchdog forced handoff", data_out[2], 32'd1);
        rd(2, SA);
        #1;
        chk("timeout flag set", data_out[2], 32'h8000_0000);
        tick();
        idle_all(); peek(2, SA);
        #1;
        chk("timeout flag cleared", data_out[2], 32'd0);
        lock_wr(1, 32'd0); tick();
`else
        lock_wr(0, 32'd1); tick();
        idle_all(); lock_wr(1, 32'd1); tick();
        idle_all(); peek(2, LA); peek(3, SA);
        for (int k = 1; k <= 10000; k++) begin
            tick();
            if (k % 2500 == 0) begin
                #1;
                chk($sformatf("no-watchdog owner @%0d", k), data_out[2], 32'd0);
                chk($sformatf("no-watchdog status @%0d", k), data_out[3], 32'h2);
            end
        end
        lock_wr(0, 32'd0); tick();
        idle_all(); lock_wr(1, 32'd0); tick();
`endif

        // Randomized traffic with occasional mid-run resets
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst_n = ($urandom_range(0, 499) != 0);
            for (int i = 0; i < N; i++) begin
                r = $urandom_range(0, 9);
                case (r)
                    0: begin
                        if ($urandom_range(0, 7) == 0) v = $urandom;
                        else v = ($urandom_range(0, 2) == 0) ? 32'd0 : 32'd1;
                        lock_wr(i, v);
                    end
                    1: rd(i, SA);
                    2: rd(i, LA);
                    3: begin
                        select_in[i] = 1'b1;
                        wr_en_in[i]  = 1'($urandom_range(0, 1));
                        addr_in[i]   = 32'($urandom_range(0, 31)) * 32'd4;
                        data_in[i]   = $urandom;
                    end
                    default: begin
                        select_in[i] = 1'b0;
                        wr_en_in[i]  = 1'($urandom_range(0, 1));
                        case ($urandom_range(0, 3))
                            0:       addr_in[i] = LA;
                            1:       addr_in[i] = SA;
                            default: addr_in[i] = $urandom;
                        endcase
                        data_in[i]   = $urandom;
                    end
                endcase
            end
            tick();
        end

        idle_all();
        rst_n = 1'b1;
        tick();
        tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/lock_arbiter.md
# lock_arbiter

Parametrised successor to the two-core accelerator lock. Arbitrates exclusive ownership of one memory-mapped accelerator among N_CLIENTS cores. Adds:
- sticky request queueing,
- round-robin fairness,
- direct owner-to-owner handoff,
- a pending-request status register,
- an optional inactivity watchdog that force-releases a stalled owner.

Sits between the cores' data-bus select/address/data signals and the accelerator's slave port.

## Interface
Parameters:
- N_CLIENTS, 2, number of sharing cores; legal range 1..31.
- LOCK_ADDR, 32'd84, lock register address. Write 1 = request, write 0 = release/cancel. Read = owner index.
- STATUS_ADDR, 32'd88, read-only status register address.
- TIMEOUT_CYCLES, 1024, owner-inactivity limit in cycles; must be ≥2. Used only with LOCK_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- addr_in[0:N_CLIENTS-1]  in  32  per-core address.
- wr_en_in[0:N_CLIENTS-1]  in  1  per-core write enable.
- select_in[0:N_CLIENTS-1]  in  1  per-core device select.
- data_in[0:N_CLIENTS-1]  in  32  per-core write data.
- data_from_accel  in  32  accelerator read data.
- data_to_accel  out  32  owner write data.
- addr_o  out  32  owner address to accelerator.
- wr_en_o  out  1  owner write enable to accelerator.
- accel_select_o  out  1  owner select to accelerator.
- data_out[0:N_CLIENTS-1]  out  32  per-core read data.

## Operation
- State: owner (32 bits; value N_CLIENTS = FREE), pending[N_CLIENTS-1:0], rr_ptr (index of the last granted client), timeout counter, to_flag.
- FSM has two states: FREE (owner==N_CLIENTS) and OWNED(k).
- A lock write means select_in[i] & wr_en_in[i] & addr_in[i]==LOCK_ADDR. Data 1 = request, data 0 = release/cancel. Any other data value is ignored.
- A request from a non-owner sets pending[i]. The bit stays set until it is granted or cancelled.
- A request from the current owner has no effect.
- A 0-write from a non-owner clears pending[i].
- A 0-write from the owner releases the lock.
- Grant candidates are pending | new requests this cycle, excluding the owner.
- Round-robin search starts at rr_ptr+1 and wraps modulo N_CLIENTS. The first candidate found wins.
- On grant: owner←winner, rr_ptr←winner, pending[winner]←0.
- FREE with any candidate → OWNED(winner) at the next edge.
- OWNED(k) with release: if candidates exist → OWNED(winner) at the same edge (direct handoff). Otherwise → FREE.
- A release and a cancel in the same cycle are both applied. A cancelled client is not a candidate.
- Accelerator mux in OWNED(k): addr_o, wr_en_o and accel_select_o follow client k. data_to_accel = wr_en_in[k] ? data_in[k] : 0.
- In FREE, all four accelerator outputs are 0.
- Accesses to LOCK_ADDR or STATUS_ADDR are forwarded to the accelerator like any other address. The accelerator ignores them.
- data_out[i], combinational:
  - addr_in[i]==LOCK_ADDR → owner.
  - addr_in[i]==STATUS_ADDR → {to_flag, pending zero-extended to 31 bits}.
  - Otherwise, i==owner → data_from_accel.
  - Otherwise → 0.

## Timing
- Reset (rst_n low at an edge): owner=N_CLIENTS, pending=0, rr_ptr=N_CLIENTS-1 (so client 0 wins first), counter=0, to_flag=0.
- Outputs in reset: addr_o=0, wr_en_o=0, accel_select_o=0, data_to_accel=0, data_out[i]=N_CLIENTS on LOCK_ADDR, 0 elsewhere.
- Reset mid-ownership drops the owner and all pending requests.
- Grant latency: a request write in cycle T gives owner visible and muxed in cycle T+1 when FREE.
- Handoff latency: a release in cycle T gives the new owner in cycle T+1, with no FREE cycle between.
- data_out and the accelerator mux are purely combinational from the current owner. There is no added read latency.
- Status read-clear: a non-write select of STATUS_ADDR by any client in cycle T returns to_flag=1 if set, and clears it at the end of T.
- A forced release in the same cycle as the read-clear: the set wins.

## Configuration
- LOCK_TIMEOUT_EN defined:
  - The counter is cleared on grant or on any select_in[owner] cycle. Otherwise it increments while OWNED.
  - When the counter reaches TIMEOUT_CYCLES-1 with no owner select in that cycle, the next edge performs a forced release. This uses normal handoff rules and sets to_flag.
  - The counter saturates; it never wraps.
- LOCK_TIMEOUT_EN undefined:
  - No counter is present.
  - to_flag is tied to 0.
  - TIMEOUT_CYCLES is ignored.
  - The lock is held until explicit release.

## Test plan
- Reset, then core 0 writes 1 to 84 → cycle+1: LOCK_ADDR reads 0 on all cores; addr_o follows core 0; core 1 non-lock reads return 0.
- N_CLIENTS=4, owner 0; cores 1, 2, 3 request, then owner releases 3 times → owners 1, 2, 3 with no FREE cycle between them; STATUS reads 0xE, 0xC, 0x8, 0x0.
- Same cycle from FREE, cores 0 and 1 request after rr_ptr=0 → core 1 granted; core 0's pending bit stays set (STATUS=0x1).
- Owner 1 releases while core 0 cancels in the same cycle → FREE; LOCK_ADDR reads N_CLIENTS; STATUS=0.
- With LOCK_TIMEOUT_EN, TIMEOUT_CYCLES=8: owner 0 idle, core 1 pending → core 1 owns 8 cycles after the last owner select; STATUS reads 0x80000000 once, then 0x0.
- Without LOCK_TIMEOUT_EN, owner idle for 10000 cycles → owner unchanged; bit 31 always 0.
